// File: rtl/float_pkg.sv
// Shared FPU types: RISC-V rounding modes, exception flags, and
// helpers for building special IEEE-754 encodings of any format width.
package float_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } round_mode_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Quiet NaN with only the fraction MSB set, sign 0.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

  // Largest finite magnitude, sign bit excluded.
  function automatic logic [63:0] max_finite(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd2) << man_w;
    r = r | ((64'd1 << man_w) - 64'd1);
    return r;
  endfunction

endpackage

// File: rtl/float_round_incr.sv
// Combinational round-up decision from sign, mantissa lsb, round/sticky bits
// and the rounding mode; unknown mode encodings fall back to round-to-nearest-even.
module float_round_incr
  import float_pkg::*;
(
  input  logic        sign,
  input  logic        lsb,
  input  logic [1:0]  sticky,
  input  round_mode_t round_mode,
  output logic        round_up
);

  always_comb begin
    round_up = 1'b0;
    case (round_mode)
      RTZ:     round_up = 1'b0;
      RDN:     round_up = (|sticky) & sign;
      RUP:     round_up = (|sticky) & ~sign;
      RMM:     round_up = sticky[1];
      default: round_up = sticky[1] & (sticky[0] | lsb);
    endcase
  end

endmodule

// File: rtl/float_round_pack.sv
// Two-stage round-and-pack: S1 registers the rounded mantissa, S2 renormalises,
// resolves overflow/subnormal/specials and registers the packed word and flags.
module float_round_pack
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W:0]         in_exp,
  input  logic [MAN_W:0]         in_man,
  input  logic [1:0]             in_sticky,
  input  round_mode_t            in_round_mode,
  input  logic                   in_nan,
  input  logic                   in_inf,
  input  logic                   in_zero,
  input  logic                   in_nv,
  input  logic                   in_dz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output fflags_t                out_fflags
);

  localparam int DW = EXP_W + MAN_W + 1;
  localparam logic [DW-1:0]    NAN_WORD = DW'(canonical_nan(EXP_W, MAN_W));
  localparam logic [DW-1:0]    MAX_MAG  = DW'(max_finite(EXP_W, MAN_W));
  localparam logic [EXP_W+1:0] EXP_OVF  = (EXP_W+2)'((1 << EXP_W) - 1);

  logic              s1_valid, s1_sign, s1_inexact;
  logic              s1_nan, s1_inf, s1_zero, s1_nv, s1_dz;
  logic [EXP_W:0]    s1_exp;
  logic [MAN_W+1:0]  s1_man_r;
  round_mode_t       s1_mode;
  logic              s1_adv, s2_adv, round_up;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  float_round_incr u_incr (
    .sign       (in_sign),
    .lsb        (in_man[0]),
    .sticky     (in_sticky),
    .round_mode (in_round_mode),
    .round_up   (round_up)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_man_r   <= '0;
      s1_inexact <= 1'b0;
      s1_mode    <= RNE;
      s1_nan     <= 1'b0;
      s1_inf     <= 1'b0;
      s1_zero    <= 1'b0;
      s1_nv      <= 1'b0;
      s1_dz      <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_exp     <= in_exp;
        s1_man_r   <= {1'b0, in_man} + (MAN_W+2)'(round_up);
        s1_inexact <= |in_sticky;
        s1_mode    <= in_round_mode;
        s1_nan     <= in_nan;
        s1_inf     <= in_inf;
        s1_zero    <= in_zero;
        s1_nv      <= in_nv;
        s1_dz      <= in_dz;
      end
    end
  end

  logic [EXP_W+1:0] exp_n;
  logic [MAN_W-1:0] frac;
  logic             ovf, to_inf;
  logic [DW-1:0]    pack_data;
  fflags_t          pack_flags;

  // A subnormal that rounds up into the hidden bit becomes the smallest normal.
  always_comb begin
    exp_n = {1'b0, s1_exp};
    frac  = s1_man_r[MAN_W-1:0];
    if (s1_man_r[MAN_W+1]) begin
      exp_n = {1'b0, s1_exp} + (EXP_W+2)'(1);
      frac  = s1_man_r[MAN_W:1];
    end else if (s1_exp == '0 && s1_man_r[MAN_W]) begin
      exp_n = (EXP_W+2)'(1);
    end
    ovf = (exp_n >= EXP_OVF);

    case (s1_mode)
      RTZ:     to_inf = 1'b0;
      RDN:     to_inf = s1_sign;
      RUP:     to_inf = ~s1_sign;
      default: to_inf = 1'b1;
    endcase

    pack_flags    = '0;
    pack_flags.nv = s1_nv;
    pack_flags.dz = s1_dz;
    if (s1_nan) begin
      pack_data = NAN_WORD;
    end else if (s1_inf) begin
      pack_data = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_zero) begin
      pack_data = {s1_sign, (DW-1)'(0)};
    end else if (ovf) begin
      pack_data     = to_inf ? {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {s1_sign, MAX_MAG[DW-2:0]};
      pack_flags.of = 1'b1;
      pack_flags.nx = 1'b1;
    end else begin
      pack_data     = {s1_sign, exp_n[EXP_W-1:0], frac};
      pack_flags.uf = s1_inexact & (exp_n == '0);
      pack_flags.nx = s1_inexact;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_fflags <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data   <= pack_data;
        out_fflags <= pack_flags;
      end
    end
  end

endmodule

// File: tb/tb_float_round_pack.sv
// Bench for float_round_pack (binary32): directed corner cases plus randomized
// traffic with random backpressure, scored against an arithmetic reference model.
module tb_float_round_pack;
  import float_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        in_sign;
  logic [8:0]  in_exp;
  logic [23:0] in_man;
  logic [1:0]  in_sticky;
  round_mode_t in_round_mode;
  logic        in_nan, in_inf, in_zero, in_nv, in_dz;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  fflags_t     out_fflags;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb[$];
  exp_t next_exp;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  float_round_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_man        (in_man),
    .in_sticky     (in_sticky),
    .in_round_mode (in_round_mode),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .in_zero       (in_zero),
    .in_nv         (in_nv),
    .in_dz         (in_dz),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_fflags    (out_fflags)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: the round-away amount is judged from the discarded fraction
  // (0 exact, 1 below half, 2 exactly half, 3 above half).
  function automatic exp_t model(input logic s, input int e, input int m, input int st,
                                 input int mode, input logic nan, input logic inf,
                                 input logic zero, input logic nv, input logic dz);
    exp_t r;
    int   md, up, v, ex;
    logic of, uf, nx, big;
    of = 0; uf = 0; nx = 0;
    md = (mode > 4) ? 0 : mode;
    if (nan)       r.data = 32'h7FC0_0000;
    else if (inf)  r.data = {s, 31'h7F80_0000};
    else if (zero) r.data = {s, 31'h0};
    else begin
      case (md)
        0: up = (st == 3 || (st == 2 && (m % 2) == 1)) ? 1 : 0;
        1: up = 0;
        2: up = (s && st != 0) ? 1 : 0;
        3: up = (!s && st != 0) ? 1 : 0;
        default: up = (st >= 2) ? 1 : 0;
      endcase
      v  = m + up;
      ex = e;
      if (v >= (1 << 24)) begin
        v  = v / 2;
        ex = ex + 1;
      end else if (ex == 0 && v >= (1 << 23)) begin
        ex = 1;
      end
      nx = (st != 0);
      if (ex >= 255) begin
        of  = 1;
        nx  = 1;
        big = (md == 0 || md == 4 || (md == 3 && !s) || (md == 2 && s));
        r.data = big ? {s, 31'h7F80_0000} : {s, 31'h7F7F_FFFF};
      end else begin
        r.data = {s, 8'(ex), 23'(v % (1 << 23))};
        uf = nx && (ex == 0);
      end
    end
    r.flags = {nv, dz, of, uf, nx};
    return r;
  endfunction

  task automatic apply_stimulus(input logic s, input int e, input int m, input int st,
                                input int mode, input logic nan, input logic inf,
                                input logic zero, input logic nv, input logic dz);
    in_valid      = 1'b1;
    in_sign       = s;
    in_exp        = 9'(e);
    in_man        = 24'(m);
    in_sticky     = 2'(st);
    in_round_mode = round_mode_t'(3'(mode));
    in_nan        = nan;
    in_inf        = inf;
    in_zero       = zero;
    in_nv         = nv;
    in_dz         = dz;
    next_exp      = model(s, e, m, st, mode, nan, inf, zero, nv, dz);
  endtask

  // Called at a negedge: scores the transfers about to happen, then advances one clock.
  task automatic cycle();
    exp_t e;
    #1;
    if (reset) begin
      @(posedge clock);
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_output("spurious_out", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check_output("out_data", 64'(out_data), 64'(e.data));
          check_output("out_fflags", 64'(out_fflags), 64'(e.flags));
        end
      end
      if (in_valid && in_ready) sb.push_back(next_exp);
      @(posedge clock);
    end
    @(negedge clock);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) cycle();
    cycle();
    cycle();
    check_output("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input logic s, input int e, input int m,
                          input int st, input int mode, input logic nan, input logic inf,
                          input logic zero, input logic nv, input logic dz,
                          input logic [31:0] d, input logic [4:0] f);
    out_ready = 1'b1;
    apply_stimulus(s, e, m, st, mode, nan, inf, zero, nv, dz);
    next_exp.data  = d;
    next_exp.flags = f;
    cycle();
    in_valid = 1'b0;
    #1 check_output({tag, "_lat1"}, 64'(out_valid), 64'd0);
    cycle();
    #1 check_output({tag, "_lat2"}, 64'(out_valid), 64'd1);
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e, m, k;
    reset = 1'b1;
    out_ready = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    @(negedge clock);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_data", 64'(out_data), 64'd0);
    check_output("rst_out_fflags", 64'(out_fflags), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);

    directed("rne_tie",  0, 127, 'h800001, 2, 0, 0, 0, 0, 0, 0, 32'h3F80_0002, 5'b00001);
    directed("mode6_rne",0, 127, 'h800001, 2, 6, 0, 0, 0, 0, 0, 32'h3F80_0002, 5'b00001);
    directed("carry",    0, 127, 'hFFFFFF, 3, 0, 0, 0, 0, 0, 0, 32'h4000_0000, 5'b00001);
    directed("ovf_rne",  0, 255, 'h800000, 0, 0, 0, 0, 0, 0, 0, 32'h7F80_0000, 5'b00101);
    directed("ovf_rtz",  0, 255, 'h800000, 0, 1, 0, 0, 0, 0, 0, 32'h7F7F_FFFF, 5'b00101);
    directed("ovf_rdn",  1, 255, 'h800000, 0, 2, 0, 0, 0, 0, 0, 32'hFF80_0000, 5'b00101);
    directed("sub_rup",  0, 0,   'h7FFFFF, 3, 3, 0, 0, 0, 0, 0, 32'h0080_0000, 5'b00001);
    directed("sub_rtz",  0, 0,   'h7FFFFF, 3, 1, 0, 0, 0, 0, 0, 32'h007F_FFFF, 5'b00011);
    directed("nan_nv",   1, 5,   'h000001, 3, 0, 1, 1, 0, 1, 0, 32'h7FC0_0000, 5'b10000);
    directed("inf_dz",   1, 5,   'h800000, 3, 0, 0, 1, 0, 0, 1, 32'hFF80_0000, 5'b01000);
    directed("zero",     1, 5,   'h800000, 3, 0, 0, 0, 1, 0, 0, 32'h8000_0000, 5'b00000);

    // Backpressure: two inputs fill the pipe, the third waits until out_ready rises.
    drain();
    out_ready = 1'b0;
    apply_stimulus(0, 100, 'h812345, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    apply_stimulus(1, 120, 'h8ABCDE, 3, 3, 0, 0, 0, 0, 0);
    cycle();
    apply_stimulus(0, 130, 'hC00001, 2, 4, 0, 0, 0, 0, 0);
    #1 check_output("bp_full", 64'(in_ready), 64'd0);
    cycle();
    #1 check_output("bp_hold", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 check_output("bp_simul", 64'(in_ready), 64'd1);
    cycle();
    drain();

    // Reset with two transactions in flight must discard both.
    apply_stimulus(0, 90, 'h900000, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    apply_stimulus(1, 91, 'h900001, 3, 0, 0, 0, 0, 0, 0);
    cycle();
    in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1 check_output("rst_flight_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      #1 check_output("rst_flight_quiet", 64'(out_valid), 64'd0);
      cycle();
    end
    directed("post_rst", 0, 127, 'h800001, 2, 0, 0, 0, 0, 0, 0, 32'h3F80_0002, 5'b00001);

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      e = 0;
      else if (k == 1) e = $urandom_range(253, 300);
      else             e = $urandom_range(1, 254);
      k = $urandom_range(0, 3);
      if (e == 0)      m = $urandom_range(0, 'hFFFFFF);
      else if (k == 0) m = ($urandom_range(0, 1) != 0) ? 'hFFFFFF : 'hFFFFFE;
      else             m = 'h800000 | $urandom_range(0, 'h7FFFFF);
      k = $urandom_range(0, 19);
      apply_stimulus(1'($urandom_range(0, 1)), e, m, $urandom_range(0, 3),
                     $urandom_range(0, 7), k == 0, k == 1, k == 2,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
